ifetch_queue_unit: RTL
======================

Name: ifetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch unit for one thread.
- Issues line-granular icache requests with up to MAX_OUTSTANDING in flight.
- Unpacks ISSUE_W opcodes per returned line into an opcode queue, and presents one opcode per cycle to the execution stage with a valid/ready handshake.
- Handles thread activate, PIPE_HALT and software-forced halt, and returns a single THREAD_HALT response to the thread manager once fully drained.

Parameters:
- ISSUE_W, 2, opcodes per icache line; line data is ISSUE_W*OPC_W bits, slot 0 in the LSBs.
- OPC_W, 32, opcode width in bits.
- QDEPTH, 8, opcode queue entries; must be ≥ ISSUE_W*MAX_OUTSTANDING.
- MAX_OUTSTANDING, 2, maximum icache requests in flight.
- PC_W, ADDR_FIELD_WIDTH, line-index counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- tm_req  in  request_t  thread manager command; THREAD_ACTIVATE or THREAD_HALT
- tm_rsp  out  request_t  one-cycle THREAD_HALT completion
- CORE_BASE_ADDR  in  core_base_addr_t  fetch base; ADDR field used
- icache_req  out  request_t  registered line request, vld held one cycle
- icache_busy  in  1  icache cannot accept a request this cycle
- icache_rsp  in  request_t  returned line, in request order; vld one cycle
- ex_vld  out  1  ex_opcode valid
- ex_opcode  out  OPC_W  head opcode
- ex_ready  in  1  execution stage accepts the head this cycle
- fetch_active  out  1  high whenever state != IDLE
- q_level  out  $clog2(QDEPTH+1)  queue occupancy

Behaviour:
Reset
- icache_req=0, tm_rsp=0, ex_vld=0, queue empty, pc=0, outstanding=0, state=IDLE.
- Reset asserted mid-operation aborts everything immediately.
- Responses arriving after reset are ignored while in IDLE.

FSM states: IDLE, FETCH, DRAIN, HALT_RSP.
- IDLE→FETCH: tm_req.vld && access_type==THREAD_ACTIVATE. pc and outstanding are cleared.
- FETCH→DRAIN: a PIPE_HALT is unpacked, or tm_req.vld && THREAD_HALT is received (forced halt).
- DRAIN→HALT_RSP: outstanding==0 && queue empty.
- HALT_RSP→IDLE: always. In HALT_RSP, tm_rsp.vld=1 for exactly one cycle with access_type=THREAD_HALT and all other fields 0.
- THREAD_ACTIVATE outside IDLE is ignored. THREAD_HALT in IDLE is ignored.

Issue (FETCH only)
- Issue when !icache_busy && outstanding<MAX_OUTSTANDING && (QDEPTH − q_level) ≥ ISSUE_W*(outstanding+1). The credit rule guarantees no overflow.
- Request fields: vld=1, access_type=NULL_ACCESS, addr=CORE_BASE_ADDR.ADDR+pc, all other fields 0.
- Next cycle pc increments by 1 and wraps modulo 2^PC_W. icache_req returns to 0 the following cycle unless another issue qualifies (back-to-back issue allowed).

Response handling
- Each icache_rsp.vld decrements outstanding.
- In FETCH, slots are pushed in order slot0..slotISSUE_W−1.
- The first slot equal to PIPE_HALT is not pushed; it and all later slots in that line are dropped, and the state moves to DRAIN.
- In DRAIN and IDLE, responses only decrement outstanding and push nothing.
- An issue and a response in the same cycle leave outstanding unchanged.

Queue
- Push up to ISSUE_W and pop 1 in the same cycle.
- Pop occurs when ex_vld && ex_ready.
- ex_vld = queue non-empty; ex_opcode = head, driven from the registered queue.
- A forced halt clears the queue in the same cycle, and ex_vld=0 on the next cycle.
- A PIPE_HALT halt does not clear the queue: opcodes before the halt drain normally.
- Overflow or underflow is a design error; an assertion checks it.

Latency
- Activate to first icache_req.vld: 1 cycle (activate at cycle N, request visible at N+1 when not busy).
- icache_rsp to ex_vld: 1 cycle.

Test Plan:
1. Basic fetch: ISSUE_W=2, base 0x1000, activate, no busy, line data {0x22,0x11} → requests at 0x1000, 0x1001; ex_opcode 0x11 then 0x22; pc order preserved.
2. Mid-line halt: line {PIPE_HALT,0x33} then a further outstanding line {0x44,0x55} → 0x33 delivered; PIPE_HALT, 0x44 and 0x55 not delivered; a single tm_rsp THREAD_HALT after 0x33 is popped and outstanding==0; then IDLE.
3. Backpressure: ex_ready=0 for 20 cycles with continuous responses → q_level saturates ≤8; issue stops once credit is insufficient; no overflow; order intact after ex_ready=1.
4. Busy/outstanding limit: icache_busy toggles every other cycle and responses are delayed 5 cycles → never more than 2 requests in flight; no request issued while busy.
5. Forced halt: THREAD_HALT while queue holds 5 opcodes and 2 requests are outstanding → ex_vld=0 next cycle; late responses discarded; tm_rsp asserted once after both responses return.
6. Reset mid-fetch: drop reset with 3 opcodes queued → all outputs 0 and state IDLE; a subsequent THREAD_ACTIVATE restarts at base+0.

Source files
------------

// File: rtl/ifetch_queue_unit_if.sv
// ifetch_queue_unit_if: thread manager, icache and execution-stage signals of the fetch unit.
interface ifetch_queue_unit_if #(
    parameter int ISSUE_W = 2,
    parameter int OPC_W   = 32,
    parameter int QDEPTH  = 8,
    parameter int ADDR_W  = 16
);
    typedef struct packed {
        logic                     vld;
        logic [1:0]               access_type;
        logic [ADDR_W-1:0]        addr;
        logic [ISSUE_W*OPC_W-1:0] data;
    } request_t;
    typedef struct packed {
        logic [7:0]        core_id;
        logic [ADDR_W-1:0] addr;
    } core_base_addr_t;
    request_t                    tm_req, tm_rsp, icache_req, icache_rsp;
    core_base_addr_t             CORE_BASE_ADDR;
    logic                        icache_busy, ex_vld, ex_ready, fetch_active;
    logic [OPC_W-1:0]            ex_opcode;
    logic [$clog2(QDEPTH+1)-1:0] q_level;
    modport master (
        input  tm_req, CORE_BASE_ADDR, icache_busy, icache_rsp, ex_ready,
        output tm_rsp, icache_req, ex_vld, ex_opcode, fetch_active, q_level
    );
    modport slave (
        output tm_req, CORE_BASE_ADDR, icache_busy, icache_rsp, ex_ready,
        input  tm_rsp, icache_req, ex_vld, ex_opcode, fetch_active, q_level
    );
endinterface

// File: rtl/ifetch_queue_unit.sv
// ifetch_queue_unit: single-thread line fetch with bounded outstanding icache requests,
// an opcode queue feeding the execution stage, and PIPE_HALT / forced-halt draining.
module ifetch_queue_unit #(
    parameter int               ISSUE_W         = 2,
    parameter int               OPC_W           = 32,
    parameter int               QDEPTH          = 8,
    parameter int               MAX_OUTSTANDING = 2,
    parameter int               PC_W            = 16,
    parameter logic [OPC_W-1:0] PIPE_HALT       = '1
) (
    input logic clk,
    input logic reset,
    ifetch_queue_unit_if.master bus
);
    localparam logic [1:0] NULL_ACCESS = 2'd0, THREAD_ACTIVATE = 2'd1, THREAD_HALT = 2'd2;
    localparam int LW  = $clog2(QDEPTH + 1);
    localparam int LW1 = LW + 1;
    localparam int AW  = $clog2(QDEPTH);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW  = $clog2(ISSUE_W + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT_RSP} state_t;
    state_t state, state_nxt;

    logic [OPC_W-1:0] mem [QDEPTH];
    logic [AW-1:0]    rptr, wptr;
    logic [LW-1:0]    count;
    logic [OW-1:0]    out, eff_out;
    logic [PC_W-1:0]  pc, eff_pc, req_addr;
    logic             req_vld, act, hlt, fetch, clear, issue, pop, rsp_dec, halt_hit;
    logic [SW-1:0]    hit_idx, push_n;
    logic [LW1-1:0]   lvl_nxt;
    logic             unused_bits;

    assign act     = bus.tm_req.vld && bus.tm_req.access_type == THREAD_ACTIVATE;
    assign hlt     = bus.tm_req.vld && bus.tm_req.access_type == THREAD_HALT;
    assign fetch   = state == FETCH;
    assign clear   = fetch && hlt;
    assign eff_out = state == IDLE ? '0 : out;
    assign eff_pc  = state == IDLE ? '0 : pc;
    // Activation issues in the same cycle so the first request appears one cycle later.
    assign issue   = (fetch || (state == IDLE && act)) && !bus.icache_busy
                     && int'(eff_out) < MAX_OUTSTANDING
                     && QDEPTH - int'(count) >= ISSUE_W * (int'(eff_out) + 1);
    assign pop     = bus.ex_vld && bus.ex_ready;
    assign rsp_dec = bus.icache_rsp.vld && out != '0 && state != IDLE;

    always_comb begin
        hit_idx = SW'(ISSUE_W);
        for (int i = ISSUE_W - 1; i >= 0; i--)
            if (bus.icache_rsp.data[i*OPC_W +: OPC_W] == PIPE_HALT) hit_idx = SW'(i);
    end

    assign halt_hit = bus.icache_rsp.vld && hit_idx != SW'(ISSUE_W);
    assign push_n   = (fetch && bus.icache_rsp.vld && !hlt) ? hit_idx : '0;
    assign lvl_nxt  = clear ? '0 : LW1'(count) + LW1'(push_n) - LW1'(pop);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (act) state_nxt = FETCH;
            FETCH:   if (hlt || halt_hit) state_nxt = DRAIN;
            DRAIN:   if (out == '0 && count == '0) state_nxt = HALT_RSP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.tm_rsp             = '0;
        bus.tm_rsp.vld         = state == HALT_RSP;
        bus.tm_rsp.access_type = state == HALT_RSP ? THREAD_HALT : NULL_ACCESS;
        bus.icache_req         = '0;
        bus.icache_req.vld     = req_vld;
        bus.icache_req.addr    = req_addr;
        bus.fetch_active       = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pc       <= '0;
            out      <= '0;
            req_vld  <= 1'b0;
            req_addr <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
        end else begin
            pc       <= eff_pc + PC_W'(issue);
            out      <= eff_out + OW'(issue) - OW'(rsp_dec);
            req_vld  <= issue;
            req_addr <= issue ? bus.CORE_BASE_ADDR.addr + eff_pc : '0;
            rptr     <= clear ? '0 : AW'((int'(rptr) + int'(pop)) % QDEPTH);
            wptr     <= clear ? '0 : AW'((int'(wptr) + int'(push_n)) % QDEPTH);
            count    <= lvl_nxt[LW-1:0];
        end

    always_ff @(posedge clk)
        for (int i = 0; i < ISSUE_W; i++)
            if (SW'(i) < push_n) mem[AW'((int'(wptr) + i) % QDEPTH)] <= bus.icache_rsp.data[i*OPC_W +: OPC_W];

    assign bus.ex_vld    = count != '0;
    assign bus.ex_opcode = mem[rptr];
    assign bus.q_level   = count;

    assign unused_bits = ^{bus.tm_req.addr, bus.tm_req.data, bus.icache_rsp.access_type,
                           bus.icache_rsp.addr, bus.CORE_BASE_ADDR.core_id};

    assert property (@(posedge clk) disable iff (!reset) lvl_nxt <= LW1'(QDEPTH));
endmodule
